// File: rtl/game_sequencer.sv
// game_sequencer: round control FSM (idle, countdown, play, pause, game over) with survival timer and high score.
module game_sequencer #(
  parameter int COUNT_START = 3,
  parameter int MAX_SEC = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  output logic       game_rst,
  output logic       run_en,
  output logic       game_over,
  output logic [2:0] state,
  output logic [1:0] countdown,
  output logic [7:0] seconds,
  output logic [7:0] high_score
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] COUNTDOWN = 3'd1;
  localparam logic [2:0] PLAY = 3'd2;
  localparam logic [2:0] PAUSED = 3'd3;
  localparam logic [2:0] OVER = 3'd4;
  localparam logic [1:0] CS = 2'(COUNT_START);
  localparam logic [7:0] MS = 8'(MAX_SEC);
  logic       start_q, start_rise;
  logic [2:0] state_n;
  logic [1:0] cd_n;
  logic [7:0] sec_n, hs_n;
  assign start_rise = start & ~start_q;
  assign game_rst = (state == IDLE) | (state == COUNTDOWN);
  assign run_en = state == PLAY;
  assign game_over = state == OVER;
  always_comb begin
    state_n = state;
    cd_n = countdown;
    sec_n = seconds;
    hs_n = high_score;
    case (state)
      IDLE, OVER: if (start_rise) begin
        state_n = COUNTDOWN;
        cd_n = CS;
        sec_n = 8'd0;
      end
      COUNTDOWN: if (tick_1hz) begin
        cd_n = (countdown > 2'd1) ? countdown - 2'd1 : 2'd0;
        state_n = (countdown > 2'd1) ? COUNTDOWN : PLAY;
      end
      PLAY: if (hit) begin
        // score compares the pre-increment value; the tick is dropped on a hit
        state_n = OVER;
        hs_n = (seconds > high_score) ? seconds : high_score;
      end else begin
        sec_n = (tick_1hz && seconds < MS) ? seconds + 8'd1 : seconds;
        state_n = pause ? PAUSED : PLAY;
      end
      PAUSED: state_n = (start_rise && pause) ? IDLE : (pause ? PAUSED : PLAY);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      countdown <= 2'd0;
      seconds <= 8'd0;
      high_score <= 8'd0;
      start_q <= 1'b0;
    end else begin
      state <= state_n;
      countdown <= cd_n;
      seconds <= sec_n;
      high_score <= hs_n;
      start_q <= start;
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed checks of game_sequencer, with a second MAX_SEC=4 instance for saturation.
module tb_game_sequencer;
  logic       clk = 0, rst_n = 0, tick_1hz = 0, start = 0, pause = 0, hit = 0;
  logic       game_rst, run_en, game_over, s_game_rst, s_run_en, s_game_over;
  logic [2:0] state, s_state;
  logic [1:0] countdown, s_countdown;
  logic [7:0] seconds, high_score, s_seconds, s_high_score;
  int         vectors = 0, errors = 0;

  game_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .start(start), .pause(pause), .hit(hit),
    .game_rst(game_rst), .run_en(run_en), .game_over(game_over), .state(state),
    .countdown(countdown), .seconds(seconds), .high_score(high_score)
  );

  game_sequencer #(.COUNT_START(3), .MAX_SEC(4)) sat (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .start(start), .pause(pause), .hit(hit),
    .game_rst(s_game_rst), .run_en(s_run_en), .game_over(s_game_over), .state(s_state),
    .countdown(s_countdown), .seconds(s_seconds), .high_score(s_high_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1;
      step();
      tick_1hz = 0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    chk("rst_state", state, 0);
    chk("rst_countdown", countdown, 0);
    chk("rst_seconds", seconds, 0);
    chk("rst_high", high_score, 0);
    chk("rst_game_rst", game_rst, 1);
    chk("rst_run_en", run_en, 0);
    chk("rst_game_over", game_over, 0);
    step();
    #2 rst_n = 1;
    step();
    chk("idle_hold", state, 0);
    // round 1: countdown 3,2,1 then play
    start = 1;
    step();
    chk("cd_enter", state, 1);
    chk("cd_3", countdown, 3);
    step();
    chk("start_once", state, 1);
    chk("cd_hold", countdown, 3);
    start = 0;
    hit = 1;
    step();
    hit = 0;
    chk("cd_hit_ignored", state, 1);
    ticks(1);
    chk("cd_2", countdown, 2);
    ticks(1);
    chk("cd_1", countdown, 1);
    chk("cd_game_rst", game_rst, 1);
    ticks(1);
    chk("play_state", state, 2);
    chk("play_cd0", countdown, 0);
    chk("play_game_rst", game_rst, 0);
    chk("play_run_en", run_en, 1);
    ticks(5);
    chk("r1_sec5", seconds, 5);
    chk("sat_sec4_a", s_seconds, 4);
    hit = 1;
    step();
    hit = 0;
    chk("r1_over", state, 4);
    chk("r1_sec", seconds, 5);
    chk("r1_high", high_score, 5);
    chk("r1_game_over", game_over, 1);
    chk("r1_run_en", run_en, 0);
    chk("sat_high4", s_high_score, 4);
    ticks(2);
    chk("over_sec_held", seconds, 5);
    // round 2: hit coincident with tick
    start = 1;
    step();
    start = 0;
    chk("r2_cd", state, 1);
    chk("r2_cd3", countdown, 3);
    chk("r2_sec_clr", seconds, 0);
    ticks(3);
    chk("r2_play", state, 2);
    ticks(2);
    tick_1hz = 1;
    hit = 1;
    step();
    tick_1hz = 0;
    hit = 0;
    chk("r2_over", state, 4);
    chk("r2_sec2", seconds, 2);
    chk("r2_high5", high_score, 5);
    // round 3: pause, saturation, abort
    start = 1;
    step();
    start = 0;
    ticks(3);
    ticks(7);
    chk("r3_sec7", seconds, 7);
    pause = 1;
    tick_1hz = 1;
    step();
    tick_1hz = 0;
    chk("r3_paused", state, 3);
    chk("r3_pause_tick", seconds, 8);
    chk("r3_pause_run_en", run_en, 0);
    ticks(3);
    hit = 1;
    step();
    hit = 0;
    chk("r3_paused_hold", state, 3);
    chk("r3_sec_held", seconds, 8);
    pause = 0;
    step();
    chk("r3_resume", state, 2);
    ticks(2);
    chk("r3_sec10", seconds, 10);
    chk("sat_sec4_b", s_seconds, 4);
    pause = 1;
    step();
    chk("r3_paused2", state, 3);
    start = 1;
    step();
    start = 0;
    pause = 0;
    chk("r3_abort", state, 0);
    chk("r3_abort_high", high_score, 5);
    step();
    chk("r3_idle_stay", state, 0);
    // round 4: async reset mid-play, start held through release
    start = 1;
    step();
    start = 0;
    ticks(3);
    ticks(7);
    chk("r4_sec7", seconds, 7);
    #2 start = 1;
    rst_n = 0;
    #1;
    chk("async_state", state, 0);
    chk("async_sec", seconds, 0);
    chk("async_high", high_score, 0);
    chk("async_game_rst", game_rst, 1);
    chk("async_run_en", run_en, 0);
    step();
    chk("rst_held_idle", state, 0);
    #2 rst_n = 1;
    step();
    chk("rel_cd", state, 1);
    chk("rel_cd3", countdown, 3);
    step();
    chk("rel_single", countdown, 3);
    start = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter COUNT_START, default 3, meaning the pre-play countdown length in 1 Hz ticks (legal 1..3).
REQ-002 The block SHALL have parameter MAX_SEC, default 99, meaning the saturation value of the survival-time counter (legal 1..255).
REQ-003 Port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port tick_1hz, input, 1 bit: single-cycle pulse once per second, synchronous to clk.
REQ-006 Port start, input, 1 bit: debounced level from the start switch; only its rising edge is used.
REQ-007 Port pause, input, 1 bit: debounced level; high requests pause.
REQ-008 Port hit, input, 1 bit: single-cycle pulse from the game datapath on collision or score exhaustion.
REQ-009 Port game_rst, output, 1 bit: active-high reset to the game/VGA datapath.
REQ-010 Port run_en, output, 1 bit: motion/scoring enable to the game datapath.
REQ-011 Port game_over, output, 1 bit: high while in OVER.
REQ-012 Port state, output, 3 bits: encoding IDLE=0, COUNTDOWN=1, PLAY=2, PAUSED=3, OVER=4.
REQ-013 Port countdown, output, 2 bits: remaining countdown ticks for the seven-segment display.
REQ-014 Port seconds, output, 8 bits: survival time of the current or last round.
REQ-015 Port high_score, output, 8 bits: best seconds since reset.

Function
REQ-016 start_q SHALL register start each cycle; start_rise = start AND NOT start_q; start held high SHALL produce exactly one start_rise.
REQ-017 state, countdown, seconds, high_score and start_q SHALL be registers; game_rst, run_en and game_over SHALL be decoded combinationally from state.
REQ-018 Decode: game_rst=1 in IDLE and COUNTDOWN, else 0; run_en=1 only in PLAY; game_over=1 only in OVER.
REQ-019 IDLE: on start_rise -> COUNTDOWN next cycle, countdown<=COUNT_START, seconds<=0.
REQ-020 COUNTDOWN: on tick_1hz with countdown>1, countdown decrements; on tick_1hz with countdown==1 -> PLAY, countdown<=0; start_rise and hit SHALL be ignored.
REQ-021 PLAY: on tick_1hz, seconds increments by 1, saturating at MAX_SEC (no wrap).
REQ-022 PLAY: on hit -> OVER; hit SHALL take priority over pause and tick_1hz in the same cycle, and seconds SHALL NOT increment in that cycle.
REQ-023 PLAY: on pause high and no hit -> PAUSED; a coincident tick_1hz SHALL still increment seconds.
REQ-024 PAUSED: tick_1hz and hit SHALL be ignored; seconds held; pause low -> PLAY; start_rise with pause high -> IDLE (abort, high_score unchanged).
REQ-025 On the PLAY->OVER transition edge, high_score SHALL load seconds if seconds > high_score (value before any same-cycle increment), else hold.
REQ-026 OVER: seconds and high_score held; on start_rise -> COUNTDOWN, countdown<=COUNT_START, seconds<=0.
REQ-027 Every state transition SHALL take effect on the clk edge at which its triggering input is sampled (one-cycle latency to outputs).
REQ-028 Unused state encodings 5..7 SHALL return to IDLE on the next clk edge.

Reset
REQ-029 rst_n low SHALL immediately and asynchronously force state=IDLE, countdown=0, seconds=0, high_score=0, start_q=0, giving game_rst=1, run_en=0, game_over=0.
REQ-030 rst_n assertion mid-round (any state) SHALL discard the round, including high_score.
REQ-031 Release of rst_n SHALL be followed by normal operation from the first subsequent clk edge; a start level already high at release SHALL produce one start_rise.

Verification
REQ-032 Reset, start pulse, 3 ticks -> countdown 3,2,1 then state=PLAY, game_rst 1->0, run_en=1 on the third tick edge.
REQ-033 PLAY, 5 ticks then hit -> state=OVER, seconds=5, high_score=5, game_over=1, run_en=0.
REQ-034 Second round: 2 ticks then hit in the same cycle as a tick -> seconds=2, high_score stays 5.
REQ-035 MAX_SEC=4, 10 ticks in PLAY -> seconds saturates at 4.
REQ-036 PLAY, pause high across 3 ticks -> seconds unchanged, state=PAUSED; pause low -> PLAY; start_rise while paused -> IDLE, high_score unchanged.
REQ-037 rst_n pulsed low mid-cycle during PLAY with seconds=7 -> outputs reset immediately without waiting for clk; start held high through release -> single COUNTDOWN entry.
